// File: rtl/add16_share_sched.sv
// Round-robin scheduler sharing one external approximate 16-bit adder among N
// requesters, with an approximate-operation budget refilled every WINDOW cycles.
module add16_share_sched #(
    parameter int N          = 4,
    parameter int WINDOW     = 64,
    parameter int APPROX_MAX = 16,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int BW = (APPROX_MAX > 0) ? $clog2(APPROX_MAX + 1) : 1,
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [16*N-1:0] req_a,
    input  logic [16*N-1:0] req_b,
    input  logic [N-1:0]    req_approx,
    output logic [15:0]     ax_a,
    output logic [15:0]     ax_b,
    input  logic [16:0]     ax_o,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [16:0]     rsp_sum,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_approx,
    output logic [BW-1:0]   budget_left
);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] cand;
    logic [IW-1:0] grant_id;
    logic          grant_found;
    logic          advance_r;
    logic          advance_s1;
    logic          handshake;
    logic          grant_ax;
    logic [15:0]   grant_a;
    logic [15:0]   grant_b;

    logic [WW-1:0] win_cnt;
    logic          wrap;
    logic [BW-1:0] budget_eff;
    logic [BW-1:0] budget_next;

    logic          s1_valid;
    logic          s1_use_ax;
    logic [15:0]   s1_a;
    logic [15:0]   s1_b;
    logic [IW-1:0] s1_id;

    assign advance_r  = !rsp_valid || rsp_ready;
    assign advance_s1 = !s1_valid || advance_r;

    // Scan upward from rr_ptr, wrapping at N, for the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(rr_ptr) + k) % N);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (advance_s1 && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign handshake = advance_s1 && grant_found;
    assign grant_a   = req_a[{grant_id, 4'b0000} +: 16];
    assign grant_b   = req_b[{grant_id, 4'b0000} +: 16];

    // A grant landing on the wrap cycle already spends from the refilled budget.
    assign wrap        = (win_cnt == WW'(WINDOW - 1));
    assign budget_eff  = wrap ? BW'(APPROX_MAX) : budget_left;
    assign grant_ax    = req_approx[grant_id] && (budget_eff != '0);
    assign budget_next = (handshake && grant_ax) ? budget_eff - 1'b1 : budget_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            budget_left <= BW'(APPROX_MAX);
            rr_ptr      <= '0;
        end else begin
            win_cnt     <= wrap ? '0 : win_cnt + 1'b1;
            budget_left <= budget_next;
            if (handshake) begin
                rr_ptr <= (grant_id == IW'(N - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // The shared adder inputs only move for approximate operations, so exact
    // traffic leaves the external datapath quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_use_ax <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            ax_a      <= '0;
            ax_b      <= '0;
        end else begin
            if (advance_s1) begin
                s1_valid <= handshake;
                if (handshake) begin
                    s1_a      <= grant_a;
                    s1_b      <= grant_b;
                    s1_id     <= grant_id;
                    s1_use_ax <= grant_ax;
                end
            end
            if (handshake && grant_ax) begin
                ax_a <= grant_a;
                ax_b <= grant_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_sum    <= '0;
            rsp_id     <= '0;
            rsp_approx <= 1'b0;
        end else if (advance_r && s1_valid) begin
            rsp_valid  <= 1'b1;
            rsp_sum    <= s1_use_ax ? ax_o : ({1'b0, s1_a} + {1'b0, s1_b});
            rsp_id     <= s1_id;
            rsp_approx <= s1_use_ax;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: doc/add16_share_sched.md
Name: add16_share_sched

Overview:
- Schedules a shared 16-bit approximate adder (add16u-class combinational datapath, external to this block) between N requesters.
- Round-robin arbitration across requesters.
- Accuracy controller: per-request approximate/exact choice, limited by an approximate-operation budget per fixed cycle window.
- Exact results come from an internal 16+16->17 adder; approximate results come from the external adder's O.
- Two-stage pipeline with valid/ready backpressure on a single response channel.

Parameters:
- N, 4, number of requesters (2..8).
- WINDOW, 64, budget window length in cycles (>=2).
- APPROX_MAX, 16, approximate operations allowed per window (0..WINDOW).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  N  request valid, one bit per requester.
- req_ready  out  N  grant/accept, one-hot or zero.
- req_a  in  16*N  operand A; requester i occupies bits [16i+15:16i].
- req_b  in  16*N  operand B; same packing as req_a.
- req_approx  in  N  requester i asks for approximate add.
- ax_a  out  16  operand A to the external approximate adder.
- ax_b  out  16  operand B to the external approximate adder.
- ax_o  in  17  result from the external approximate adder (combinational from ax_a/ax_b).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_sum  out  17  result.
- rsp_id  out  clog2(N)  index of the originating requester.
- rsp_approx  out  1  1 = result from the approximate adder.
- budget_left  out  clog2(APPROX_MAX+1)  approximate operations remaining in the current window.

Behaviour:
- Reset:
  - s1_valid=0, rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_approx=0.
  - rr_ptr=0, win_cnt=0, budget_left=APPROX_MAX, ax_a=ax_b=0.
  - Reset mid-operation discards in-flight operations; no response is produced for them.
- Pipeline:
  - Stage S1 registers {a, b, id, use_ax}.
  - Output register R holds the response.
  - advance_r = !rsp_valid | rsp_ready.
  - advance_s1 = !s1_valid | advance_r.
- Grant (combinational, same cycle):
  - When advance_s1=1, the first requester with req_valid=1 starting at rr_ptr and scanning upward mod N gets req_ready=1.
  - Otherwise req_ready=0.
  - Handshake = req_valid[i] & req_ready[i].
  - req_ready never asserts for a requester with req_valid=0.
- On handshake by requester g:
  - S1 <= operands, id=g, use_ax = req_approx[g] & (budget_eff>0).
  - rr_ptr <= (g+1) mod N.
  - No handshake: rr_ptr is held.
- S1 -> R, when advance_r & s1_valid:
  - rsp_sum <= use_ax ? ax_o : (a+b, full 17-bit, carry in bit 16).
  - rsp_id <= id, rsp_approx <= use_ax, rsp_valid <= 1.
- R drain: if rsp_ready and no S1 advance, rsp_valid <= 0.
- ax_a/ax_b:
  - Equal S1 a/b while use_ax=1.
  - Otherwise hold their last value, so the shared adder does not toggle for exact operations (power gating of the datapath).
- Latency and throughput:
  - Handshake in cycle T gives rsp_valid in cycle T+2 with no backpressure.
  - Throughput is 1 operation/cycle.
  - Held R stalls S1; held S1 deasserts all req_ready.
  - R holds stable while rsp_valid & !rsp_ready.
- Budget window:
  - win_cnt counts 0..WINDOW-1, then wraps.
  - wrap = (win_cnt==WINDOW-1).
  - budget_eff = wrap ? APPROX_MAX : budget_left. The wrap-cycle grant draws from the new window.
  - Next budget_left = budget_eff - (handshake & use_ax).
  - budget_left never underflows.
  - An approximate request with budget_eff=0 is served exact: use_ax=0, rsp_approx=0. This is not an error.
- APPROX_MAX=0: every operation is exact and ax_a/ax_b never change from 0.
- Exact sums wrap nothing: 0xFFFF+0xFFFF = 0x1FFFE.

Test Plan:
- Reset then idle 10 cycles -> rsp_valid=0, req_ready=0, budget_left=16, ax_a=ax_b=0.
- Requester 1 sends a=0xFFFF, b=0x0001, approx=0 in cycle 5 -> cycle 7: rsp_valid=1, rsp_sum=0x10000, rsp_id=1, rsp_approx=0; ax_a/ax_b unchanged.
- All 4 requesters hold valid for 8 cycles, rsp_ready=1 -> grant order 0,1,2,3,0,1,2,3; one response per cycle in that id order.
- Requester 2 streams approx=1; bench drives ax_o=0x0ABCD -> first 16 responses have rsp_approx=1 and rsp_sum=0x0ABCD; the 17th and later use the exact sum and rsp_approx=0 until win_cnt wraps; budget_left returns to 16 then decrements once per approximate grant.
- Approx grant exactly on the wrap cycle with budget_left=0 -> use_ax=1, budget_left becomes 15.
- rsp_ready=0 for 5 cycles with 3 requests pending -> R and S1 fill, req_ready=0, R stable. Release rsp_ready -> responses in grant order with no loss or duplication.
- Assert rst while S1 and R are both full -> next cycle rsp_valid=0, budget_left=16, rr_ptr=0; no stale response later.
